// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
package ras_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XCHG  = 2'd1,
      DRAIN = 2'd2
   } ras_state_t;

   localparam int unsigned OVF_MAX = 15;

endpackage

// File: rtl/ras_ctrl_stack.sv
// LIFO storage for return addresses; the full flag reserves one slot,
// so usable capacity is STACK_DEPTH-1 entries.
module stack #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_push,
   input  logic                           i_pop,
   input  logic [DATA_WIDTH-1:0]          i_data,
   output logic [DATA_WIDTH-1:0]          o_top,
   output logic                           o_empty,
   output logic                           o_full,
   output logic [$clog2(STACK_DEPTH)-1:0] o_count
);

   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [STACK_DEPTH];
   logic [PTR_W-1:0]      r_ptr;

   assign o_empty = (r_ptr == '0);
   assign o_full  = (r_ptr == PTR_W'(STACK_DEPTH - 1));
   assign o_count = r_ptr;
   assign o_top   = r_mem[r_ptr - 1'b1];

   always_ff @(posedge clk) begin
      if (!rst && i_push && !o_full) begin
         r_mem[r_ptr] <= i_data;
      end
   end

   // Push wins if both are requested; the controller never issues both.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_push && !o_full) begin
         r_ptr <= r_ptr + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_ptr <= r_ptr - 1'b1;
      end
   end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: sequences call/return hints onto one stack,
// registers the return prediction, tracks overflow depth and drains on flush.
module ras_ctrl
   import ras_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned OVF_W       = $clog2(OVF_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_call,
   input  logic              req_ret,
   input  logic [ADDR_W-1:0] req_ret_addr,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic [ADDR_W-1:0] pred_addr,
   output logic [OVF_W-1:0]  ovf_cnt,
   output logic              draining
);

   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

   ras_state_t        r_state;
   ras_state_t        w_next;
   logic [ADDR_W-1:0] r_xchg_addr;
   logic [OVF_W-1:0]  r_ovf_cnt;
   logic              r_pred_valid;
   logic              r_pred_hit;
   logic [ADDR_W-1:0] r_pred_addr;

   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_push_data;
   logic [OVF_W-1:0]  w_ovf_next;
   logic              w_xchg_load;
   logic              w_pred_fire;
   logic              w_pred_hit;
   logic [ADDR_W-1:0] w_pred_addr;
   logic [ADDR_W-1:0] w_stk_top;
   logic              w_stk_empty;
   logic              w_stk_full;
   logic [PTR_W-1:0]  w_stk_count;
   logic              w_stk_last;

   stack #(
      .DATA_WIDTH  (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_data),
      .o_top   (w_stk_top),
      .o_empty (w_stk_empty),
      .o_full  (w_stk_full),
      .o_count (w_stk_count)
   );

   assign req_ready  = (r_state == IDLE);
   assign draining   = (r_state == DRAIN);
   assign pred_valid = r_pred_valid;
   assign pred_hit   = r_pred_hit;
   assign pred_addr  = r_pred_addr;
   assign ovf_cnt    = r_ovf_cnt;
   assign w_accept   = req_valid & req_ready & ~flush;
   assign w_stk_last = (w_stk_count == PTR_W'(1));

   always_comb begin
      w_next      = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_push_data = req_ret_addr;
      w_ovf_next  = r_ovf_cnt;
      w_xchg_load = 1'b0;
      w_pred_fire = 1'b0;
      w_pred_hit  = 1'b0;
      w_pred_addr = '0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_pred_fire = req_ret;
               case ({req_call, req_ret})
                  2'b10: begin
                     if (!w_stk_full) begin
                        w_push = 1'b1;
                     end else if (r_ovf_cnt != '1) begin
                        w_ovf_next = r_ovf_cnt + 1'b1;
                     end
                  end
                  2'b01: begin
                     if (r_ovf_cnt != '0) begin
                        w_ovf_next = r_ovf_cnt - 1'b1;
                     end else if (!w_stk_empty) begin
                        w_pop       = 1'b1;
                        w_pred_hit  = 1'b1;
                        w_pred_addr = w_stk_top;
                     end
                  end
                  2'b11: begin
                     // Swap is split: pop now, push the new link next cycle.
                     if (r_ovf_cnt != '0) begin
                        w_next = IDLE;
                     end else if (w_stk_empty) begin
                        w_push = 1'b1;
                     end else begin
                        w_pop       = 1'b1;
                        w_pred_hit  = 1'b1;
                        w_pred_addr = w_stk_top;
                        w_xchg_load = 1'b1;
                        w_next      = XCHG;
                     end
                  end
                  default: w_next = IDLE;
               endcase
            end
         end
         XCHG: begin
            w_push      = 1'b1;
            w_push_data = r_xchg_addr;
            w_next      = IDLE;
         end
         DRAIN: begin
            w_pop = ~w_stk_empty;
            if (w_stk_empty || w_stk_last) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
      if (flush) begin
         w_push      = 1'b0;
         w_ovf_next  = '0;
         w_pred_fire = 1'b0;
         if (r_state != DRAIN) begin
            w_pop  = 1'b0;
            w_next = w_stk_empty ? IDLE : DRAIN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ovf_cnt    <= '0;
         r_xchg_addr  <= '0;
         r_pred_valid <= 1'b0;
         r_pred_hit   <= 1'b0;
         r_pred_addr  <= '0;
      end else begin
         r_state      <= w_next;
         r_ovf_cnt    <= w_ovf_next;
         r_pred_valid <= w_pred_fire;
         if (w_xchg_load) begin
            r_xchg_addr <= req_ret_addr;
         end
         if (w_pred_fire) begin
            r_pred_hit  <= w_pred_hit;
            r_pred_addr <= w_pred_addr;
         end
      end
   end

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: a queue-based reference model predicts each
// cycle's status and every return prediction; a monitor compares DUT outputs.
module tb_ras_ctrl;

   localparam int unsigned CAP     = 7;
   localparam int unsigned OVF_SAT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_call = 1'b0;
   logic        req_ret = 1'b0;
   logic [31:0] req_ret_addr = '0;
   logic        pred_valid;
   logic        pred_hit;
   logic [31:0] pred_addr;
   logic [3:0]  ovf_cnt;
   logic        draining;

   ras_ctrl #(
      .ADDR_W      (32),
      .STACK_DEPTH (8),
      .OVF_W       (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_call     (req_call),
      .req_ret      (req_ret),
      .req_ret_addr (req_ret_addr),
      .pred_valid   (pred_valid),
      .pred_hit     (pred_hit),
      .pred_addr    (pred_addr),
      .ovf_cnt      (ovf_cnt),
      .draining     (draining)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ready;
      bit          drain;
      bit          pv;
      bit          hit;
      int unsigned ovf;
      logic [31:0] addr;
   } st_t;

   typedef struct {
      bit          hit;
      logic [31:0] addr;
   } pr_t;

   st_t st_q[$];
   pr_t pred_q[$];

   // Reference model state
   localparam int M_IDLE = 0, M_SWAP = 1, M_DRAIN = 2;
   logic [31:0] stk[$];
   int unsigned ovf = 0;
   int          mode = M_IDLE;
   logic [31:0] swap_addr = '0;
   bit          hold_hit = 1'b0;
   logic [31:0] hold_addr = '0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rs, input bit fl, input bit v, input bit c,
                       input bit r, input logic [31:0] a);
      st_t         s;
      pr_t         p;
      bit          pv;
      bit          hit;
      logic [31:0] pa;
      @(negedge clk);
      rst = rs; flush = fl; req_valid = v; req_call = c; req_ret = r; req_ret_addr = a;
      pv = 1'b0; hit = 1'b0; pa = '0;
      if (rs) begin
         stk.delete();
         ovf = 0; mode = M_IDLE; hold_hit = 1'b0; hold_addr = '0;
      end else if (mode == M_DRAIN) begin
         void'(stk.pop_back());
         if (stk.size() == 0) mode = M_IDLE;
      end else if (fl) begin
         ovf = 0;
         mode = (stk.size() != 0) ? M_DRAIN : M_IDLE;
      end else if (mode == M_SWAP) begin
         stk.push_back(swap_addr);
         mode = M_IDLE;
      end else if (v) begin
         if (c && !r) begin
            if (stk.size() < CAP) stk.push_back(a);
            else if (ovf < OVF_SAT) ovf++;
         end else if (r && !c) begin
            pv = 1'b1;
            if (ovf > 0) ovf--;
            else if (stk.size() != 0) begin hit = 1'b1; pa = stk.pop_back(); end
         end else if (r && c) begin
            pv = 1'b1;
            if (ovf > 0) begin end
            else if (stk.size() == 0) stk.push_back(a);
            else begin hit = 1'b1; pa = stk.pop_back(); swap_addr = a; mode = M_SWAP; end
         end
      end
      if (pv) begin
         p.hit = hit; p.addr = pa;
         pred_q.push_back(p);
         hold_hit = hit; hold_addr = pa;
      end
      s.ready = (mode == M_IDLE);
      s.drain = (mode == M_DRAIN);
      s.pv = pv; s.hit = hold_hit; s.addr = hold_addr; s.ovf = ovf;
      st_q.push_back(s);
   endtask

   task automatic call(input logic [31:0] a); step(0, 0, 1, 1, 0, a); endtask
   task automatic ret();                      step(0, 0, 1, 0, 1, 32'h0); endtask
   task automatic swap(input logic [31:0] a); step(0, 0, 1, 1, 1, a); endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
   endtask
   task automatic do_flush();                 step(0, 1, 0, 0, 0, 32'h0); endtask

   // Monitor: compares status every cycle and pops a prediction per pulse.
   initial begin
      st_t s;
      pr_t p;
      forever begin
         @(posedge clk);
         #2;
         if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("req_ready", 32'(req_ready), 32'(s.ready));
            chk("draining", 32'(draining), 32'(s.drain));
            chk("ovf_cnt", 32'(ovf_cnt), s.ovf);
            chk("pred_valid", 32'(pred_valid), 32'(s.pv));
            chk("pred_hit_hold", 32'(pred_hit), 32'(s.hit));
            chk("pred_addr_hold", pred_addr, s.addr);
            if (pred_valid === 1'b1) begin
               if (pred_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL pred_unexpected: got a pulse, expected none at %0t", $time);
               end else begin
                  p = pred_q.pop_front();
                  chk("pred_hit", 32'(pred_hit), 32'(p.hit));
                  chk("pred_addr", pred_addr, p.addr);
               end
            end
         end
      end
   end

   initial begin
      int unsigned r;
      step(1, 0, 0, 0, 0, 32'h0);
      step(1, 0, 0, 0, 0, 32'h0);

      // Basic push/pop and empty return
      call(32'h100); call(32'h200); ret(); ret(); ret(); idle(1);

      // Fill, overflow, unwind overflow then hit 7th address
      for (int i = 1; i <= 9; i++) call(32'h1000 + 32'(i) * 4);
      ret(); ret(); ret(); idle(1);
      do_flush(); idle(8);

      // Swap
      call(32'h10); call(32'h20); swap(32'h30); ret(); ret(); ret(); idle(1);

      // Flush with 3 entries, then with full stack plus overflow
      call(32'h40); call(32'h44); call(32'h48); do_flush(); idle(4); ret();
      for (int i = 0; i < 9; i++) call(32'h2000 + 32'(i));
      do_flush(); idle(9); ret();

      // Flush with a valid return; flush during swap; flush during drain
      call(32'h50); call(32'h54);
      step(0, 1, 1, 0, 1, 32'h0); idle(3);
      call(32'h60); call(32'h64); swap(32'h68); do_flush(); idle(3); ret();
      call(32'h70); call(32'h74); call(32'h78); do_flush(); do_flush(); idle(3);

      // Reset mid-drain
      call(32'h80); call(32'h84); call(32'h88); call(32'h8c);
      do_flush(); idle(1);
      step(1, 0, 0, 0, 0, 32'h0);
      ret(); idle(1);

      // Overflow saturation
      for (int i = 0; i < 24; i++) call(32'h3000 + 32'(i));
      ret(); do_flush(); idle(9);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         step(r == 0, r > 94, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom);
      end
      idle(12);

      @(posedge clk);
      #4;
      chk("pred_queue_empty", 32'(pred_q.size()), 32'h0);
      chk("status_queue_empty", 32'(st_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
